branch_stack_unit: RTL and testbench

- Registered control-flow unit for the PucCPU core.
- Decodes the jump/call/return opcode group against the zero flag, owns the program counter, and maintains a parametrised return-address stack.
- Sits between instruction fetch and the ALU decoder; all flow-control state changes happen on the clock edge.
- Adds stack depth/width generalisation, stall support, and sticky overflow/underflow error flags.

---
 rtl/branch_stack_unit.sv | 143 ++++++++++++++
 tb/tb_branch_stack_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_stack_unit.sv
// Program-counter and return-address-stack control for the PucCPU core.
// Decodes jump/call/return against the zero flag and updates pc/stack on the clock edge.
module branch_stack_unit #(
    parameter int PC_WIDTH     = 5,
    parameter int OPCODE_WIDTH = 5,
    parameter int STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]     RESET_PC   = '0,
    parameter logic [OPCODE_WIDTH-1:0] OP_JMP     = OPCODE_WIDTH'('h10),
    parameter logic [OPCODE_WIDTH-1:0] OP_IF0JUMP = OPCODE_WIDTH'('h11),
    parameter logic [OPCODE_WIDTH-1:0] OP_IF1JUMP = OPCODE_WIDTH'('h12),
    parameter logic [OPCODE_WIDTH-1:0] OP_CALL    = OPCODE_WIDTH'('h13),
    parameter logic [OPCODE_WIDTH-1:0] OP_CAL0    = OPCODE_WIDTH'('h14),
    parameter logic [OPCODE_WIDTH-1:0] OP_CAL1    = OPCODE_WIDTH'('h15),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET     = OPCODE_WIDTH'('h16),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET0    = OPCODE_WIDTH'('h17),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET1    = OPCODE_WIDTH'('h18)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    input  logic                         stall,
    input  logic [OPCODE_WIDTH-1:0]      op_code,
    input  logic [PC_WIDTH-1:0]          jmp_addr,
    input  logic                         zero_flag,
    input  logic                         err_clear,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         push,
    output logic                         pop,
    output logic                         jmp,
    output logic                         cal,
    output logic                         ret,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stack_top;
    logic [SP_W-1:0]     sp_dec;
    logic                adv;
    logic                take_jmp;
    logic                take_call;
    logic                take_ret;
    logic                do_push;
    logic                do_pop;

    assign adv         = instr_valid & ~stall & ~reset;
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign sp_dec      = sp - SP_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_top   = stack_mem[sp_dec[IDX_W-1:0]];
    assign do_push     = adv & take_call & ~stack_full;
    assign do_pop      = adv & take_ret & ~stack_empty;

    // Decode: conditional ops with a false condition fall through as sequential.
    always_comb begin
        take_jmp  = 1'b0;
        take_call = 1'b0;
        take_ret  = 1'b0;
        case (op_code)
            OP_JMP:     take_jmp  = 1'b1;
            OP_IF0JUMP: take_jmp  = ~zero_flag;
            OP_IF1JUMP: take_jmp  = zero_flag;
            OP_CALL:    take_call = 1'b1;
            OP_CAL0:    take_call = ~zero_flag;
            OP_CAL1:    take_call = zero_flag;
            OP_RET:     take_ret  = 1'b1;
            OP_RET0:    take_ret  = ~zero_flag;
            OP_RET1:    take_ret  = zero_flag;
            default: ;
        endcase
    end

    // Stack storage carries no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

    // Control state: pc, sp, action pulses and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            sp            <= '0;
            push          <= 1'b0;
            pop           <= 1'b0;
            jmp           <= 1'b0;
            cal           <= 1'b0;
            ret           <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            push <= 1'b0;
            pop  <= 1'b0;
            jmp  <= 1'b0;
            cal  <= 1'b0;
            ret  <= 1'b0;
            // Clear first so a same-edge set below takes priority.
            if (err_clear) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end
            if (adv) begin
                if (take_jmp) begin
                    pc  <= jmp_addr;
                    jmp <= 1'b1;
                end else if (take_call) begin
                    if (do_push) begin
                        pc   <= jmp_addr;
                        sp   <= sp + SP_W'(1);
                        push <= 1'b1;
                        jmp  <= 1'b1;
                        cal  <= 1'b1;
                    end else begin
                        pc           <= pc_inc;
                        overflow_err <= 1'b1;
                    end
                end else if (take_ret) begin
                    if (do_pop) begin
                        pc  <= stack_top;
                        sp  <= sp_dec;
                        pop <= 1'b1;
                        ret <= 1'b1;
                    end else begin
                        pc            <= pc_inc;
                        underflow_err <= 1'b1;
                    end
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_stack_unit.sv
// Directed bench for branch_stack_unit: sequencing, branches, nested calls,
// overflow/underflow, stall, pc wrap and asynchronous reset.
module tb_branch_stack_unit;

    localparam logic [4:0] NOP     = 5'h00;
    localparam logic [4:0] JMP     = 5'h10;
    localparam logic [4:0] IF0JUMP = 5'h11;
    localparam logic [4:0] CALL    = 5'h13;
    localparam logic [4:0] CAL1    = 5'h15;
    localparam logic [4:0] RET     = 5'h16;
    localparam logic [4:0] RET1    = 5'h18;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       stall;
    logic [4:0] op_code;
    logic [4:0] jmp_addr;
    logic       zero_flag;
    logic       err_clear;
    logic [4:0] pc;
    logic       push, pop, jmp, cal, ret;
    logic [3:0] sp;
    logic       stack_full, stack_empty, overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;

    branch_stack_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .op_code       (op_code),
        .jmp_addr      (jmp_addr),
        .zero_flag     (zero_flag),
        .err_clear     (err_clear),
        .pc            (pc),
        .push          (push),
        .pop           (pop),
        .jmp           (jmp),
        .cal           (cal),
        .ret           (ret),
        .sp            (sp),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction, clock it, and settle 1 time unit after the edge.
    task automatic step(input logic [4:0] op, input logic [4:0] addr, input logic zf,
                        input logic vld, input logic stl, input logic clr);
        op_code     = op;
        jmp_addr    = addr;
        zero_flag   = zf;
        instr_valid = vld;
        stall       = stl;
        err_clear   = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pulses();
        return {27'd0, push, pop, jmp, cal, ret};
    endfunction

    logic [4:0] ret_pc [8];

    initial begin
        reset = 1'b1; instr_valid = 1'b0; stall = 1'b0; op_code = NOP;
        jmp_addr = '0; zero_flag = 1'b0; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_pulses", pulses(), 0);
        check("rst_errs", {overflow_err, underflow_err}, 0);
        reset = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            step(NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("seq_pc", pc, i);
            check("seq_pulses", pulses(), 0);
        end
        check("seq_sp", sp, 0);

        step(IF0JUMP, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        check("if0_false_pc", pc, 5);
        check("if0_false_jmp", jmp, 0);
        step(IF0JUMP, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        check("if0_true_pc", pc, 9);
        check("if0_true_pulses", pulses(), 5'b00100);
        step(NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("jmp_one_cycle", jmp, 0);
        check("after_jmp_pc", pc, 10);

        step(JMP, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("jmp_to2", pc, 2);
        step(CALL, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0);
        check("call_pc", pc, 20);
        check("call_sp", sp, 1);
        check("call_pulses", pulses(), 5'b10110);
        step(RET, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ret_pc", pc, 3);
        check("ret_sp", sp, 0);
        check("ret_pulses", pulses(), 5'b01001);

        // Conditional call/return with false conditions are sequential.
        step(CAL1, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cal1_false_pc", pc, 4);
        check("cal1_false_sp", sp, 0);
        step(JMP, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Eight nested calls from pc=3 to targets 10..17.
        ret_pc[0] = 5'd4;
        for (int k = 1; k < 8; k++) ret_pc[k] = 5'(10 + k);
        for (int k = 0; k < 8; k++) begin
            check("nest_full_before", stack_full, 0);
            step(CALL, 5'(10 + k), 1'b0, 1'b1, 1'b0, 1'b0);
            check("nest_pc", pc, 10 + k);
            check("nest_sp", sp, k + 1);
        end
        check("nest_full", stack_full, 1);
        step(CALL, 5'd25, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_pc", pc, 18);
        check("ovf_sp", sp, 8);
        check("ovf_err", overflow_err, 1);
        check("ovf_pulses", pulses(), 0);
        for (int k = 7; k >= 0; k--) begin
            step(RET, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("lifo_pc", pc, ret_pc[k]);
            check("lifo_sp", sp, k);
        end
        check("ovf_sticky", overflow_err, 1);
        check("lifo_empty", stack_empty, 1);
        step(RET1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("unf_pc", pc, 5);
        check("unf_err", underflow_err, 1);
        check("unf_pulses", pulses(), 0);
        step(NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_errs", {overflow_err, underflow_err}, 0);
        check("clr_pc_hold", pc, 5);
        step(RET, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("set_wins", {overflow_err, underflow_err}, 2'b01);
        check("set_wins_pc", pc, 6);
        step(NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr2_errs", {overflow_err, underflow_err}, 0);

        for (int i = 0; i < 3; i++) begin
            step(CALL, 5'd20, 1'b0, 1'b1, 1'b1, 1'b0);
            check("stall_pc", pc, 6);
            check("stall_sp", sp, 0);
            check("stall_pulses", pulses(), 0);
        end
        step(CALL, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unstall_pc", pc, 20);
        check("unstall_sp", sp, 1);
        check("unstall_pulses", pulses(), 5'b10110);
        step(CALL, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        check("invalid_pc", pc, 20);
        check("invalid_sp", sp, 1);
        check("invalid_pulses", pulses(), 0);
        step(RET, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unstall_ret_pc", pc, 7);

        step(JMP, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0);
        step(NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_pc", pc, 0);
        step(JMP, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0);
        step(CALL, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_call_pc", pc, 7);
        step(RET, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_pushed", pc, 0);

        for (int k = 1; k <= 3; k++) step(CALL, 5'(k), 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_sp", sp, 3);
        check("pre_rst_pc", pc, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc", pc, 0);
        check("async_rst_sp", sp, 0);
        check("async_rst_empty", stack_empty, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_pc", pc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
